// File: rtl/rd_txn_timer.sv
// Multi-slot AXI read-transaction watchdog.
// Each slot walks AR -> FIRST -> BURST while a shared prescaler advances its
// phase counter; a counter reaching its phase budget moves the slot to TMO,
// pulses timeout_o for that slot and sets the sticky pending flag.
module rd_txn_timer #(
  parameter int NumSlots   = 4,
  parameter int CntWidth   = 10,
  parameter int IdWidth    = 4,
  parameter int PrescWidth = 4,
  localparam int SlotW     = $clog2(NumSlots)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [PrescWidth-1:0]       presc_div_i,
  input  logic [CntWidth-1:0]         budget_ar_i,
  input  logic [CntWidth-1:0]         budget_first_i,
  input  logic [CntWidth-1:0]         budget_burst_i,
  input  logic                        alloc_valid_i,
  input  logic [IdWidth-1:0]          alloc_id_i,
  output logic                        alloc_ready_o,
  output logic [SlotW-1:0]            alloc_slot_o,
  input  logic                        ar_hs_i,
  input  logic [SlotW-1:0]            ar_slot_i,
  input  logic                        r_hs_i,
  input  logic                        r_last_i,
  input  logic [SlotW-1:0]            r_slot_i,
  input  logic [NumSlots-1:0]         flush_i,
  input  logic                        clear_i,
  output logic [NumSlots-1:0]         slot_busy_o,
  output logic [NumSlots*IdWidth-1:0] slot_id_o,
  output logic [NumSlots-1:0]         timeout_o,
  output logic [2*NumSlots-1:0]       timeout_phase_o,
  output logic                        timeout_pending_o,
  output logic                        proto_err_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_AR,
    S_FIRST,
    S_BURST,
    S_TMO
  } slot_state_e;

  logic [PrescWidth-1:0] presc_cnt;
  logic                  tick;
  logic [NumSlots-1:0]   busy;
  logic [NumSlots-1:0]   tmo_fire;
  logic [NumSlots-1:0]   perr_slot;
  logic                  alloc_fire;

  // A lowered divide value simply lets the counter run on to its natural
  // wrap, so the prescaler can never lock up.
  assign tick = (presc_cnt == presc_div_i);

  // Free-running prescaler shared by all slots.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      presc_cnt <= '0;
    end else if (tick) begin
      presc_cnt <= '0;
    end else begin
      presc_cnt <= presc_cnt + PrescWidth'(1);
    end
  end

  // Lowest-index free slot, taken from registered slot state only.
  always_comb begin
    alloc_slot_o = '0;
    for (int i = NumSlots - 1; i >= 0; i--) begin
      if (!busy[i]) alloc_slot_o = SlotW'(i);
    end
  end

  assign alloc_ready_o = ~&busy;
  assign alloc_fire    = alloc_valid_i && alloc_ready_o;
  assign slot_busy_o   = busy;

  for (genvar gi = 0; gi < NumSlots; gi++) begin : g_slot
    slot_state_e         state;
    logic [CntWidth-1:0] cnt;
    logic [CntWidth-1:0] cnt_adv;
    logic [CntWidth-1:0] budget;
    logic [IdWidth-1:0]  id;
    logic [1:0]          tphase;
    logic [1:0]          fire_phase;
    logic                tmo_pulse;
    logic                sel_alloc;
    logic                sel_ar;
    logic                sel_r;
    logic                tmo_hit;
    logic                fire;

    assign sel_alloc = alloc_fire && (alloc_slot_o == SlotW'(gi));
    assign sel_ar    = ar_hs_i && (ar_slot_i == SlotW'(gi));
    assign sel_r     = r_hs_i && (r_slot_i == SlotW'(gi));

    // Budget and phase code of the phase the slot is currently in.
    always_comb begin
      budget     = '0;
      fire_phase = 2'd0;
      case (state)
        S_AR: begin
          budget     = budget_ar_i;
          fire_phase = 2'd1;
        end
        S_FIRST: begin
          budget     = budget_first_i;
          fire_phase = 2'd2;
        end
        S_BURST: begin
          budget     = budget_burst_i;
          fire_phase = 2'd3;
        end
        default: begin
          budget     = '0;
          fire_phase = 2'd0;
        end
      endcase
    end

    // Counter expires on the tick that would complete the budget-th tick.
    assign tmo_hit = tick && (budget != '0) && (cnt == budget - CntWidth'(1));
    assign cnt_adv = (tick && (cnt != '1)) ? cnt + CntWidth'(1) : cnt;

    // Timeout only when no flush and no phase-advancing handshake this cycle.
    always_comb begin
      fire = 1'b0;
      if (!flush_i[gi] && tmo_hit) begin
        case (state)
          S_AR:    fire = !sel_ar;
          S_FIRST: fire = !sel_r;
          S_BURST: fire = !(sel_r && r_last_i);
          default: fire = 1'b0;
        endcase
      end
    end

    // Per-slot phase FSM with registered timeout pulse and phase code.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        state     <= S_IDLE;
        cnt       <= '0;
        id        <= '0;
        tphase    <= '0;
        tmo_pulse <= 1'b0;
      end else begin
        tmo_pulse <= fire;
        if (flush_i[gi]) begin
          state  <= S_IDLE;
          cnt    <= '0;
          tphase <= '0;
        end else if (fire) begin
          state  <= S_TMO;
          tphase <= fire_phase;
        end else begin
          case (state)
            S_IDLE: begin
              if (sel_alloc) begin
                state <= S_AR;
                id    <= alloc_id_i;
                cnt   <= '0;
              end
            end
            S_AR: begin
              if (sel_ar) begin
                state <= S_FIRST;
                cnt   <= '0;
              end else begin
                cnt <= cnt_adv;
              end
            end
            S_FIRST: begin
              if (sel_r) begin
                state <= r_last_i ? S_IDLE : S_BURST;
                cnt   <= '0;
              end else begin
                cnt <= cnt_adv;
              end
            end
            S_BURST: begin
              if (sel_r && r_last_i) begin
                state <= S_IDLE;
                cnt   <= '0;
              end else begin
                cnt <= cnt_adv;
              end
            end
            S_TMO: begin
              if (sel_r && r_last_i) begin
                state  <= S_IDLE;
                cnt    <= '0;
                tphase <= '0;
              end
            end
            default: begin
              state <= S_IDLE;
              cnt   <= '0;
            end
          endcase
        end
      end
    end

    assign busy[gi]      = (state != S_IDLE);
    assign tmo_fire[gi]  = fire;
    assign perr_slot[gi] = (sel_ar && (state != S_AR)) ||
                           (sel_r && ((state == S_IDLE) || (state == S_AR)));
    assign slot_id_o[gi*IdWidth +: IdWidth] = id;
    assign timeout_o[gi]                    = tmo_pulse;
    assign timeout_phase_o[2*gi +: 2]       = tphase;
  end

  // Sticky pending flag (new timeout beats clear) and protocol-error pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      timeout_pending_o <= 1'b0;
      proto_err_o       <= 1'b0;
    end else begin
      timeout_pending_o <= (|tmo_fire) | (timeout_pending_o & ~clear_i);
      proto_err_o       <= |perr_slot;
    end
  end

endmodule

// File: tb/tb_rd_txn_timer.sv
// Self-checking bench for rd_txn_timer: directed scenarios plus a randomized
// run compared every cycle against a behavioural slot model.
module tb_rd_txn_timer;
  localparam int NS = 4;
  localparam int CW = 10;
  localparam int IW = 4;
  localparam int PW = 4;
  localparam int SW = 2;
  localparam int BW = NS + NS*IW + NS + 2*NS + 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [PW-1:0]   presc_div;
  logic [CW-1:0]   b_ar, b_first, b_burst;
  logic            alloc_valid;
  logic [IW-1:0]   alloc_id;
  logic            alloc_ready;
  logic [SW-1:0]   alloc_slot;
  logic            ar_hs;
  logic [SW-1:0]   ar_slot;
  logic            r_hs, r_last;
  logic [SW-1:0]   r_slot;
  logic [NS-1:0]   flush;
  logic            clear;
  logic [NS-1:0]   busy;
  logic [NS*IW-1:0] slot_id;
  logic [NS-1:0]   tmo;
  logic [2*NS-1:0] tph;
  logic            pend, perr;

  int n_tests = 0;
  int n_fail  = 0;

  rd_txn_timer #(.NumSlots(NS), .CntWidth(CW), .IdWidth(IW), .PrescWidth(PW)) dut (
    .clk_i(clk), .rst_i(rst), .presc_div_i(presc_div),
    .budget_ar_i(b_ar), .budget_first_i(b_first), .budget_burst_i(b_burst),
    .alloc_valid_i(alloc_valid), .alloc_id_i(alloc_id),
    .alloc_ready_o(alloc_ready), .alloc_slot_o(alloc_slot),
    .ar_hs_i(ar_hs), .ar_slot_i(ar_slot),
    .r_hs_i(r_hs), .r_last_i(r_last), .r_slot_i(r_slot),
    .flush_i(flush), .clear_i(clear),
    .slot_busy_o(busy), .slot_id_o(slot_id), .timeout_o(tmo),
    .timeout_phase_o(tph), .timeout_pending_o(pend), .proto_err_o(perr)
  );

  // Behavioural model: phase 0=idle 1=AR 2=FIRST 3=BURST 4=timed out.
  int m_phase[NS];
  int m_ticks[NS];
  int m_tph[NS];
  int m_id[NS];
  int m_presc;
  bit m_pend, m_perr;
  bit [NS-1:0] m_tmo;

  task automatic model_step();
    bit tk, any_fire, a_here, ar_here, r_here, last_here, adv, active;
    int free_s, bud;
    if (rst) begin
      for (int s = 0; s < NS; s++) begin
        m_phase[s] = 0; m_ticks[s] = 0; m_tph[s] = 0; m_id[s] = 0;
      end
      m_presc = 0; m_pend = 0; m_perr = 0; m_tmo = '0;
      return;
    end
    tk = (m_presc == int'(presc_div));
    free_s = -1;
    for (int s = NS - 1; s >= 0; s--) if (m_phase[s] == 0) free_s = s;
    m_perr = 0; any_fire = 0; m_tmo = '0;
    for (int s = 0; s < NS; s++) begin
      a_here    = alloc_valid && (free_s == s);
      ar_here   = ar_hs && (int'(ar_slot) == s);
      r_here    = r_hs && (int'(r_slot) == s);
      last_here = r_here && r_last;
      if (ar_here && m_phase[s] != 1) m_perr = 1;
      if (r_here && m_phase[s] <= 1) m_perr = 1;
      bud = (m_phase[s] == 1) ? int'(b_ar) : (m_phase[s] == 2) ? int'(b_first) :
            (m_phase[s] == 3) ? int'(b_burst) : 0;
      active = (m_phase[s] >= 1) && (m_phase[s] <= 3);
      adv = (m_phase[s] == 1 && ar_here) || (m_phase[s] == 2 && r_here) ||
            (m_phase[s] == 3 && last_here);
      if (flush[s]) begin
        m_phase[s] = 0; m_ticks[s] = 0; m_tph[s] = 0;
      end else if (active && !adv && tk && bud != 0 && m_ticks[s] == bud - 1) begin
        m_tph[s] = m_phase[s]; m_phase[s] = 4; m_tmo[s] = 1; any_fire = 1;
      end else if (adv) begin
        m_ticks[s] = 0;
        if (m_phase[s] == 1) m_phase[s] = 2;
        else if (m_phase[s] == 2) m_phase[s] = r_last ? 0 : 3;
        else m_phase[s] = 0;
      end else if (active) begin
        if (tk && m_ticks[s] < 1023) m_ticks[s]++;
      end else if (m_phase[s] == 0 && a_here) begin
        m_phase[s] = 1; m_ticks[s] = 0; m_id[s] = int'(alloc_id);
      end else if (m_phase[s] == 4 && last_here) begin
        m_phase[s] = 0; m_tph[s] = 0;
      end
    end
    m_pend = any_fire ? 1'b1 : (clear ? 1'b0 : m_pend);
    m_presc = tk ? 0 : (m_presc + 1) % (1 << PW);
  endtask

  function automatic logic [BW-1:0] exp_bundle();
    logic [NS-1:0] b; logic [NS*IW-1:0] ids; logic [2*NS-1:0] ph;
    logic rdy; logic [SW-1:0] sl;
    rdy = 0; sl = '0; b = '0; ids = '0; ph = '0;
    for (int s = NS - 1; s >= 0; s--) begin
      b[s] = (m_phase[s] != 0);
      ids[s*IW +: IW] = IW'(m_id[s]);
      ph[2*s +: 2] = 2'(m_tph[s]);
      if (m_phase[s] == 0) begin rdy = 1; sl = SW'(s); end
    end
    return {b, ids, m_tmo, ph, m_pend, m_perr, rdy, sl};
  endfunction

  function automatic logic [BW-1:0] act_bundle();
    return {busy, slot_id, tmo, tph, pend, perr, alloc_ready, alloc_slot};
  endfunction

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    rst = 0; alloc_valid = 0; ar_hs = 0; r_hs = 0; r_last = 0; flush = '0; clear = 0;
  endtask

  task automatic do_reset(input int pd, input int ba, input int bf, input int bb);
    presc_div = PW'(pd); b_ar = CW'(ba); b_first = CW'(bf); b_burst = CW'(bb);
    rst = 1;
    cycle();
  endtask

  task automatic test_reset();
    logic [BW-1:0] want;
    want = '0;
    want[SW] = 1'b1;
    do_reset(0, 0, 0, 0);
    n_tests++;
    if (act_bundle() !== want) begin
      n_fail++; $display("FAIL reset_state: got %h want %h", act_bundle(), want);
    end
  endtask

  task automatic test_ar_timeout();
    do_reset(0, 4, 0, 0);
    alloc_valid = 1; alloc_id = 4'd3;
    cycle();
    n_tests++;
    if (busy !== 4'b0001 || slot_id[3:0] !== 4'd3) begin
      n_fail++; $display("FAIL ar_alloc: busy %b id %0d want 0001 id 3", busy, slot_id[3:0]);
    end
    for (int k = 2; k <= 7; k++) begin
      if (k == 5) clear = 1;
      cycle();
      n_tests++;
      if (tmo[0] !== (k == 5)) begin
        n_fail++; $display("FAIL ar_tmo_pulse: edge %0d timeout %b want %b", k, tmo[0], (k == 5));
      end
      if (k == 5) begin
        n_tests++;
        if (tph[1:0] !== 2'd1 || pend !== 1'b1) begin
          n_fail++; $display("FAIL ar_tmo_phase: phase %0d pend %b want 1 1", tph[1:0], pend);
        end
      end
    end
    clear = 1;
    cycle();
    n_tests++;
    if (pend !== 1'b0 || busy !== 4'b0001) begin
      n_fail++; $display("FAIL ar_clear: pend %b busy %b want 0 0001", pend, busy);
    end
  endtask

  task automatic test_burst();
    bit seen_tmo, seen_perr;
    seen_tmo = 0; seen_perr = 0;
    do_reset(2, 8, 8, 8);
    alloc_valid = 1; alloc_id = 4'd5;
    cycle();
    repeat (3) begin cycle(); seen_tmo |= |tmo; seen_perr |= perr; end
    ar_hs = 1; ar_slot = 2'd0;
    cycle(); seen_tmo |= |tmo; seen_perr |= perr;
    for (int b = 1; b <= 4; b++) begin
      r_hs = 1; r_slot = 2'd0; r_last = (b == 4);
      cycle(); seen_tmo |= |tmo; seen_perr |= perr;
      n_tests++;
      if (busy[0] !== (b != 4)) begin
        n_fail++; $display("FAIL burst_busy: beat %0d busy %b want %b", b, busy[0], (b != 4));
      end
    end
    cycle(); seen_tmo |= |tmo; seen_perr |= perr;
    n_tests++;
    if (seen_tmo || seen_perr || pend !== 1'b0) begin
      n_fail++; $display("FAIL burst_clean: tmo %b perr %b pend %b want 0 0 0", seen_tmo, seen_perr, pend);
    end
  endtask

  task automatic test_full();
    do_reset(0, 0, 0, 0);
    for (int i = 0; i < NS; i++) begin
      n_tests++;
      if (alloc_ready !== 1'b1 || alloc_slot !== SW'(i)) begin
        n_fail++; $display("FAIL full_alloc_slot: ready %b slot %0d want 1 %0d", alloc_ready, alloc_slot, i);
      end
      alloc_valid = 1; alloc_id = IW'(8 + i);
      cycle();
    end
    n_tests++;
    if (alloc_ready !== 1'b0 || busy !== 4'b1111) begin
      n_fail++; $display("FAIL full_ready: ready %b busy %b want 0 1111", alloc_ready, busy);
    end
    alloc_valid = 1; alloc_id = 4'hf;
    cycle();
    n_tests++;
    if (busy !== 4'b1111 || slot_id !== 16'hba98 || perr !== 1'b0) begin
      n_fail++; $display("FAIL full_ignore: busy %b ids %h perr %b want 1111 ba98 0", busy, slot_id, perr);
    end
    ar_hs = 1; ar_slot = 2'd2;
    cycle();
    r_hs = 1; r_slot = 2'd2; r_last = 1;
    cycle();
    n_tests++;
    if (alloc_ready !== 1'b1 || alloc_slot !== 2'd2 || busy !== 4'b1011) begin
      n_fail++; $display("FAIL full_free: ready %b slot %0d busy %b want 1 2 1011", alloc_ready, alloc_slot, busy);
    end
  endtask

  task automatic test_hs_vs_timeout();
    bit got;
    int waited;
    got = 0; waited = 0;
    do_reset(0, 3, 3, 0);
    alloc_valid = 1; alloc_id = 4'd6;
    cycle();
    cycle();
    cycle();
    ar_hs = 1; ar_slot = 2'd0;
    cycle();
    n_tests++;
    if (tmo !== 4'b0 || busy !== 4'b0001 || pend !== 1'b0) begin
      n_fail++; $display("FAIL hs_wins: tmo %b busy %b pend %b want 0000 0001 0", tmo, busy, pend);
    end
    for (int k = 1; k <= 10 && !got; k++) begin
      cycle();
      if (tmo[0]) begin got = 1; waited = k; end
    end
    n_tests++;
    if (!got || waited != 3 || tph[1:0] !== 2'd2) begin
      n_fail++; $display("FAIL first_tmo: got %b after %0d phase %0d want 1 3 2", got, waited, tph[1:0]);
    end
  endtask

  task automatic test_tmo_exit();
    do_reset(0, 2, 0, 0);
    alloc_valid = 1; alloc_id = 4'd1;
    cycle();
    alloc_valid = 1; alloc_id = 4'd2;
    cycle();
    repeat (4) cycle();
    n_tests++;
    if (busy !== 4'b0011 || tph[3:0] !== 4'b0101 || pend !== 1'b1) begin
      n_fail++; $display("FAIL tmo_both: busy %b ph %b pend %b want 0011 0101 1", busy, tph[3:0], pend);
    end
    r_hs = 1; r_slot = 2'd0; r_last = 1;
    cycle();
    n_tests++;
    if (busy !== 4'b0010 || perr !== 1'b0 || tph[3:0] !== 4'b0100) begin
      n_fail++; $display("FAIL tmo_late_last: busy %b perr %b ph %b want 0010 0 0100", busy, perr, tph[3:0]);
    end
    flush = 4'b0010;
    cycle();
    n_tests++;
    if (busy !== 4'b0000 || tph !== 8'h00 || pend !== 1'b1) begin
      n_fail++; $display("FAIL tmo_flush: busy %b ph %h pend %b want 0000 00 1", busy, tph, pend);
    end
    clear = 1;
    cycle();
    n_tests++;
    if (pend !== 1'b0) begin
      n_fail++; $display("FAIL tmo_clear: pend %b want 0", pend);
    end
  endtask

  task automatic test_proto_reset();
    logic [BW-1:0] want;
    want = '0;
    want[SW] = 1'b1;
    do_reset(0, 0, 0, 0);
    alloc_valid = 1; alloc_id = 4'd9;
    cycle();
    ar_hs = 1; ar_slot = 2'd0;
    cycle();
    r_hs = 1; r_slot = 2'd1; r_last = 0;
    cycle();
    n_tests++;
    if (perr !== 1'b1 || busy !== 4'b0001) begin
      n_fail++; $display("FAIL proto_r_idle: perr %b busy %b want 1 0001", perr, busy);
    end
    cycle();
    n_tests++;
    if (perr !== 1'b0) begin
      n_fail++; $display("FAIL proto_pulse_len: perr %b want 0", perr);
    end
    ar_hs = 1; ar_slot = 2'd3;
    cycle();
    n_tests++;
    if (perr !== 1'b1 || busy !== 4'b0001) begin
      n_fail++; $display("FAIL proto_ar_idle: perr %b busy %b want 1 0001", perr, busy);
    end
    r_hs = 1; r_slot = 2'd0;
    cycle();
    r_hs = 1; r_slot = 2'd0;
    cycle();
    n_tests++;
    if (busy !== 4'b0001 || perr !== 1'b0) begin
      n_fail++; $display("FAIL proto_burst: busy %b perr %b want 0001 0", busy, perr);
    end
    rst = 1;
    cycle();
    n_tests++;
    if (act_bundle() !== want) begin
      n_fail++; $display("FAIL reset_mid_burst: got %h want %h", act_bundle(), want);
    end
  endtask

  task automatic test_random();
    do_reset(0, 0, 0, 0);
    for (int c = 0; c < 3000; c++) begin
      if (c % 250 == 0) begin
        presc_div = PW'($urandom_range(0, 3));
        b_ar      = CW'($urandom_range(0, 10));
        b_first   = CW'($urandom_range(0, 10));
        b_burst   = CW'($urandom_range(0, 12));
      end
      alloc_valid = ($urandom_range(0, 99) < 35);
      alloc_id    = IW'($urandom);
      ar_hs       = ($urandom_range(0, 99) < 35);
      ar_slot     = SW'($urandom);
      r_hs        = ($urandom_range(0, 99) < 45);
      r_slot      = SW'($urandom);
      r_last      = ($urandom_range(0, 99) < 40);
      flush       = ($urandom_range(0, 99) < 4) ? NS'($urandom) : '0;
      clear       = ($urandom_range(0, 99) < 5);
      cycle();
      n_tests++;
      if (act_bundle() !== exp_bundle()) begin
        n_fail++; $display("FAIL random_cycle %0d: got %h want %h", c, act_bundle(), exp_bundle());
      end
    end
  endtask

  initial begin
    rst = 1; presc_div = '0; b_ar = '0; b_first = '0; b_burst = '0;
    alloc_valid = 0; alloc_id = '0; ar_hs = 0; ar_slot = '0;
    r_hs = 0; r_last = 0; r_slot = '0; flush = '0; clear = 0;
    test_reset();
    test_ar_timeout();
    test_burst();
    test_full();
    test_hs_vs_timeout();
    test_tmo_exit();
    test_proto_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
